// File: rtl/pe_pkg.sv
// Shared PE definitions: operand width and the operand collector state encoding.
// Collector states are named views of the lane full flags {a_full, b_full}.
package pe_pkg;
    localparam int PE_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT_A = 2'b01,
        WAIT_B = 2'b10,
        PAIRED = 2'b11
    } col_state_e;
endpackage

// File: rtl/pe_operand_lane.sv
// One operand holding register behind a demux lane: captures when empty, holds until cleared.
// ready depends only on the registered full flag, so there is no input-to-ready path.
module pe_operand_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    input  logic             clear,
    output logic [WIDTH-1:0] q,
    output logic             full,
    output logic             ready
);
    assign ready = ~full;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q    <= '0;
            full <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (valid && !full) begin
            q    <= data;
            full <= 1'b1;
        end
    end
endmodule

// File: rtl/pe_operand_collector.sv
// Pairs operand A (lane 1) and operand B (lane 2) and issues them as one registered bundle
// to the PE ALU over valid/ready, counting issued pairs modulo 2^CNT_W.
module pe_operand_collector
    import pe_pkg::*;
#(
    parameter int WIDTH = PE_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] in1,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in2,
    input  logic             in2_valid,
    output logic             in2_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] pair_count
);
    logic             a_full, b_full;
    logic [WIDTH-1:0] a_q, b_q;
    logic             issue, lane_clear;
    col_state_e       state;

    assign state      = col_state_e'({a_full, b_full});
    assign lane_clear = flush | issue;

    pe_operand_lane #(.WIDTH(WIDTH)) u_lane_a (
        .clk   (clk),
        .reset (reset),
        .data  (in1),
        .valid (in1_valid),
        .clear (lane_clear),
        .q     (a_q),
        .full  (a_full),
        .ready (in1_ready)
    );

    pe_operand_lane #(.WIDTH(WIDTH)) u_lane_b (
        .clk   (clk),
        .reset (reset),
        .data  (in2),
        .valid (in2_valid),
        .clear (lane_clear),
        .q     (b_q),
        .full  (b_full),
        .ready (in2_ready)
    );

    // A pair moves into the output slot only when the slot is empty or draining this edge.
    always_comb begin
        issue = 1'b0;
        if (!flush && state == PAIRED && (!out_valid || out_ready))
            issue = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_a       <= '0;
            op_b       <= '0;
            out_valid  <= 1'b0;
            pair_count <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (issue) begin
            op_a       <= a_q;
            op_b       <= b_q;
            out_valid  <= 1'b1;
            pair_count <= pair_count + CNT_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pe_operand_collector.sv
// Randomized and directed bench for pe_operand_collector against a queue-based pairing model.
module tb_pe_operand_collector;
    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset, flush;
    logic [WIDTH-1:0] in1, in2;
    logic             in1_valid, in2_valid, in1_ready, in2_ready;
    logic [WIDTH-1:0] op_a, op_b;
    logic             out_valid, out_ready;
    logic [CNT_W-1:0] pair_count;

    pe_operand_collector #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in1        (in1),
        .in1_valid  (in1_valid),
        .in1_ready  (in1_ready),
        .in2        (in2),
        .in2_valid  (in2_valid),
        .in2_ready  (in2_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pair_count (pair_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference: each lane is a queue holding at most one operand; the output slot is a value+flag.
    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];
    logic [WIDTH-1:0] m_opa, m_opb;
    logic             m_valid;
    int               m_issued;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        m_opa = '0;
        m_opb = '0;
        m_valid = 1'b0;
        m_issued = 0;
    endtask

    task automatic check_all();
        chk("in1_ready", 32'(in1_ready), 32'(qa.size() == 0));
        chk("in2_ready", 32'(in2_ready), 32'(qb.size() == 0));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("op_a", 32'(op_a), 32'(m_opa));
        chk("op_b", 32'(op_b), 32'(m_opb));
        chk("pair_count", 32'(pair_count), 32'(m_issued % (1 << CNT_W)));
    endtask

    // Check current outputs, take one rising edge, then advance the model with the same inputs.
    task automatic cycle();
        bit cap_a, cap_b;
        check_all();
        @(posedge clk);
        #1;
        if (flush) begin
            qa.delete();
            qb.delete();
            m_valid = 1'b0;
        end else begin
            cap_a = in1_valid && qa.size() == 0;
            cap_b = in2_valid && qb.size() == 0;
            if (qa.size() == 1 && qb.size() == 1 && (!m_valid || out_ready)) begin
                m_opa = qa.pop_front();
                m_opb = qb.pop_front();
                m_valid = 1'b1;
                m_issued++;
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            if (cap_a) qa.push_back(in1);
            if (cap_b) qb.push_back(in2);
        end
    endtask

    task automatic idle_inputs();
        in1_valid = 1'b0;
        in2_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic async_reset_pulse();
        reset = 1'b1;
        #2;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int guard;
        model_reset();
        reset = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        in1 = 8'h3C;
        in2 = 8'hA5;
        in1_valid = 1'b1;
        in2_valid = 1'b1;
        #12;
        check_all();

        // 1: capture both on the first post-reset edge, pair visible two edges later
        reset = 1'b0;
        cycle();
        idle_inputs();
        cycle();
        cycle();
        chk("t1_opa", 32'(op_a), 32'h3C);
        chk("t1_opb", 32'(op_b), 32'hA5);
        chk("t1_cnt", 32'(pair_count), 32'd1);

        // 2: A first, extra A ignored while full, then B
        in1 = 8'h11; in1_valid = 1'b1; cycle();
        in1_valid = 1'b0; cycle();
        in1 = 8'hFF; in1_valid = 1'b1; cycle();
        in1_valid = 1'b0; in2 = 8'h22; in2_valid = 1'b1; cycle();
        idle_inputs(); cycle(); cycle();
        chk("t2_opa", 32'(op_a), 32'h11);
        chk("t2_opb", 32'(op_b), 32'h22);

        // 3: stall with out_ready low, second pair waits in the lanes, then back-to-back
        out_ready = 1'b0;
        in1 = 8'h33; in2 = 8'h44; in1_valid = 1'b1; in2_valid = 1'b1; cycle();
        idle_inputs(); cycle(); cycle();
        in1 = 8'h55; in2 = 8'h66; in1_valid = 1'b1; in2_valid = 1'b1; cycle();
        idle_inputs(); cycle(); cycle();
        chk("t3_hold_opa", 32'(op_a), 32'h33);
        chk("t3_rdy", 32'({in1_ready, in2_ready}), 32'd0);
        out_ready = 1'b1; cycle();
        chk("t3_b2b_valid", 32'(out_valid), 32'd1);
        chk("t3_b2b_opa", 32'(op_a), 32'h55);
        out_ready = 1'b0; cycle();

        // 4: flush in WAIT_B with a held 7E output; lane 1 valid on the flush edge is dropped
        out_ready = 1'b1; cycle();
        out_ready = 1'b0;
        in1 = 8'h7E; in2 = 8'h01; in1_valid = 1'b1; in2_valid = 1'b1; cycle();
        idle_inputs(); cycle(); cycle();
        in1 = 8'h09; in1_valid = 1'b1; cycle();
        flush = 1'b1; in1 = 8'h0A; cycle();
        idle_inputs();
        chk("t4_opa", 32'(op_a), 32'h7E);
        chk("t4_valid", 32'(out_valid), 32'd0);
        chk("t4_rdy", 32'({in1_ready, in2_ready}), 32'd3);
        cycle();

        // 5: counter wrap
        async_reset_pulse();
        out_ready = 1'b1;
        in1_valid = 1'b1; in2_valid = 1'b1;
        guard = 0;
        while (m_issued < 256 && guard < 2000) begin
            in1 = 8'($urandom); in2 = 8'($urandom);
            cycle();
            guard++;
        end
        chk("t5_bound", 32'(m_issued), 32'd256);
        chk("t5_wrap0", 32'(pair_count), 32'd0);
        guard = 0;
        while (m_issued < 257 && guard < 10) begin
            cycle();
            guard++;
        end
        chk("t5_wrap1", 32'(pair_count), 32'd1);
        idle_inputs();
        cycle();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            in1 = 8'($urandom); in2 = 8'($urandom);
            in1_valid = 1'($urandom_range(0, 1));
            in2_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            cycle();
        end

        // 6: async reset while PAIRED with a held output
        idle_inputs();
        out_ready = 1'b0;
        in1_valid = 1'b1; in2_valid = 1'b1; cycle();
        idle_inputs(); cycle(); cycle();
        in1_valid = 1'b1; in2_valid = 1'b1; cycle();
        idle_inputs(); cycle();
        chk("t6_pre_valid", 32'(out_valid), 32'd1);
        chk("t6_pre_rdy", 32'({in1_ready, in2_ready}), 32'd0);
        async_reset_pulse();
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_cnt", 32'(pair_count), 32'd0);
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
